// File: rtl/traceback_unit_if.sv
// Traceback port bundle between traceback_unit (slave) and the MMU / decoder side (master).
interface traceback_unit_if #(
    parameter int WD_STATE    = 6,
    parameter int WD_DEPTH    = 5,
    parameter int WD_RAM_DATA = 8,
    parameter int WD_SEL      = 3
);
    logic                                i_hold;
    logic                                i_start;
    logic [WD_DEPTH-1:0]                 i_startPage;
    logic [WD_STATE-1:0]                 i_bestState;
    logic [WD_RAM_DATA-1:0]              i_dataTb;
    logic [WD_DEPTH+WD_STATE-WD_SEL-1:0] o_addressTb;
    logic                                o_tbRead;
    logic                                o_busy;
    logic                                o_decodedBit;
    logic                                o_decodeValid;
    logic                                o_done;

    modport slave (
        input  i_hold, i_start, i_startPage, i_bestState, i_dataTb,
        output o_addressTb, o_tbRead, o_busy, o_decodedBit, o_decodeValid, o_done
    );

    modport master (
        output i_hold, i_start, i_startPage, i_bestState, i_dataTb,
        input  o_addressTb, o_tbRead, o_busy, o_decodedBit, o_decodeValid, o_done
    );
endinterface

// File: rtl/traceback_unit.sv
// traceback_unit: walks survivor RAM backwards from the newest page and emits decoded bits.
// Optional macro TBU_LIFO_EN buffers the decoded bits and replays them oldest-first in FLUSH.
module traceback_unit #(
    parameter int WD_STATE    = 6,
    parameter int WD_DEPTH    = 5,
    parameter int WD_RAM_DATA = 8,
    parameter int WD_SEL      = 3,
    parameter int TB_LEN      = 32,
    parameter int DEC_LEN     = 8
) (
    input logic             i_clk,
    input logic             i_rst_n,
    traceback_unit_if.slave tb
);
    localparam int MAX_LEN = (TB_LEN > DEC_LEN) ? TB_LEN : DEC_LEN;
    localparam int WD_STEP = $clog2(MAX_LEN + 1);
    localparam logic [WD_STEP-1:0] TB_LAST  = WD_STEP'(TB_LEN - 1);
    localparam logic [WD_STEP-1:0] DEC_LAST = WD_STEP'(DEC_LEN - 1);

`ifdef TBU_LIFO_EN
    typedef enum logic [2:0] {ST_IDLE, ST_TRACE, ST_DECODE, ST_FLUSH, ST_DONE} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_TRACE, ST_DECODE, ST_DONE} state_t;
`endif

    state_t                 r_fsm, w_nextFsm;
    logic                   r_phase, w_nextPhase;
    logic [WD_STEP-1:0]     r_step, w_nextStep;
    logic [WD_STATE-1:0]    r_state, w_nextState;
    logic [WD_DEPTH-1:0]    r_page, w_nextPage;
    logic [WD_RAM_DATA-1:0] w_dataWord;
    logic                   w_survivor;
    logic                   w_tbRead;
    logic                   w_lifoPush;

    assign w_dataWord = tb.i_dataTb;
    assign w_survivor = w_dataWord[r_state[WD_SEL-1:0]];

    // r_phase=0 is the address cycle of a step, r_phase=1 the cycle the survivor word arrives.
    always_comb begin
        w_nextFsm   = r_fsm;
        w_nextPhase = r_phase;
        w_nextStep  = r_step;
        w_nextState = r_state;
        w_nextPage  = r_page;
        w_lifoPush  = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (tb.i_start) begin
                    w_nextFsm   = ST_TRACE;
                    w_nextPage  = tb.i_startPage;
                    w_nextState = tb.i_bestState;
                    w_nextStep  = '0;
                    w_nextPhase = 1'b0;
                end
            end
            ST_TRACE, ST_DECODE: begin
                if (!r_phase) begin
                    w_nextPhase = 1'b1;
                end else begin
                    w_nextPhase = 1'b0;
                    w_nextState = {r_state[WD_STATE-2:0], w_survivor};
                    w_nextPage  = r_page - 1'b1;
                    w_lifoPush  = (r_fsm == ST_DECODE);
                    if (r_fsm == ST_TRACE) begin
                        if (r_step == TB_LAST) begin
                            w_nextStep = '0;
                            w_nextFsm  = ST_DECODE;
                        end else begin
                            w_nextStep = r_step + 1'b1;
                        end
                    end else if (r_step == DEC_LAST) begin
                        w_nextStep = '0;
`ifdef TBU_LIFO_EN
                        w_nextFsm  = ST_FLUSH;
`else
                        w_nextFsm  = ST_DONE;
`endif
                    end else begin
                        w_nextStep = r_step + 1'b1;
                    end
                end
            end
`ifdef TBU_LIFO_EN
            ST_FLUSH: begin
                if (r_step == DEC_LAST) begin
                    w_nextStep = '0;
                    w_nextFsm  = ST_DONE;
                end else begin
                    w_nextStep = r_step + 1'b1;
                end
            end
`endif
            ST_DONE: w_nextFsm = ST_IDLE;
            default: w_nextFsm = ST_IDLE;
        endcase
    end

`ifdef TBU_LIFO_EN
    logic [DEC_LEN-1:0] r_lifo;
`endif

    // Hold freezes every register, which also freezes all outputs since they decode registers only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm   <= ST_IDLE;
            r_phase <= 1'b0;
            r_step  <= '0;
            r_state <= '0;
            r_page  <= '0;
`ifdef TBU_LIFO_EN
            r_lifo  <= '0;
`endif
        end else if (!tb.i_hold) begin
            r_fsm   <= w_nextFsm;
            r_phase <= w_nextPhase;
            r_step  <= w_nextStep;
            r_state <= w_nextState;
            r_page  <= w_nextPage;
`ifdef TBU_LIFO_EN
            if (w_lifoPush) begin
                r_lifo <= {r_lifo[DEC_LEN-2:0], r_state[WD_STATE-1]};
            end else if (r_fsm == ST_FLUSH) begin
                r_lifo <= {1'b0, r_lifo[DEC_LEN-1:1]};
            end
`endif
        end
    end

    assign w_tbRead       = ((r_fsm == ST_TRACE) || (r_fsm == ST_DECODE)) && !r_phase;
    assign tb.o_tbRead    = w_tbRead;
    assign tb.o_addressTb = w_tbRead ? {r_page, r_state[WD_STATE-1:WD_SEL]} : '0;
    assign tb.o_busy      = (r_fsm != ST_IDLE) && (r_fsm != ST_DONE);
    assign tb.o_done      = (r_fsm == ST_DONE);

`ifdef TBU_LIFO_EN
    // The most recently pushed bit is the oldest trellis bit, so popping restores time order.
    assign tb.o_decodeValid = (r_fsm == ST_FLUSH);
    assign tb.o_decodedBit  = (r_fsm == ST_FLUSH) && r_lifo[0];
    logic w_unusedPush;
    assign w_unusedPush = w_lifoPush;
`else
    assign tb.o_decodeValid = (r_fsm == ST_DECODE) && r_phase;
    assign tb.o_decodedBit  = (r_fsm == ST_DECODE) && r_phase && r_state[WD_STATE-1];
    logic w_unusedPush;
    assign w_unusedPush = w_lifoPush;
`endif
endmodule

// File: tb/tb_traceback_unit.sv
// Self-checking bench for traceback_unit: MMU memory model plus address/bit scoreboard.
// Works with and without TBU_LIFO_EN; expectations switch on the same macro.
module tb_traceback_unit;
    localparam int TB_LEN  = 4;
    localparam int DEC_LEN = 4;
`ifdef TBU_LIFO_EN
    localparam bit LIFO = 1'b1;
`else
    localparam bit LIFO = 1'b0;
`endif
    localparam int EXP_CYCLES = 2 * (TB_LEN + DEC_LEN) + (LIFO ? DEC_LEN : 0);
    localparam int BUDGET     = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] ram [256];
    logic [7:0] expAddr [$];
    logic       expBits [$];
    logic [7:0] obsAddr [$];
    logic       obsBits [$];
    logic [7:0] expA;
    logic       expB;

    traceback_unit_if busIf ();

    traceback_unit #(.TB_LEN(TB_LEN), .DEC_LEN(DEC_LEN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .tb      (busIf)
    );

    always #5 clk = ~clk;

    // MMU model: survivor word appears one cycle after the read, held while stalled.
    always @(posedge clk) begin
        if (busIf.o_tbRead && !busIf.i_hold) busIf.i_dataTb <= ram[busIf.o_addressTb];
    end

    // Scoreboard: every consumed read address and decoded bit is popped and compared.
    always @(negedge clk) begin
        if (rst_n && !busIf.i_hold) begin
            if (busIf.o_tbRead) begin
                obsAddr.push_back(busIf.o_addressTb);
                checks++;
                if (expAddr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL addr_unexpected: got %h, required no read", busIf.o_addressTb);
                end else begin
                    expA = expAddr.pop_front();
                    if (busIf.o_addressTb !== expA) begin
                        errors++;
                        $display("[TB] FAIL addr_seq: got %h, required %h", busIf.o_addressTb, expA);
                    end
                end
            end
            if (busIf.o_decodeValid) begin
                obsBits.push_back(busIf.o_decodedBit);
                checks++;
                if (expBits.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL bit_unexpected: got %b, required no bit", busIf.o_decodedBit);
                end else begin
                    expB = expBits.pop_front();
                    if (busIf.o_decodedBit !== expB) begin
                        errors++;
                        $display("[TB] FAIL bit_seq: got %b, required %b", busIf.o_decodedBit, expB);
                    end
                end
            end
        end
    end

    task automatic fillRam(input bit randomFill, input logic [7:0] value);
        for (int i = 0; i < 256; i++) ram[i] = randomFill ? 8'($urandom) : value;
    endtask

    // Reference traceback: decode the survivor path straight from the memory model.
    task automatic applyStimulus(input logic [4:0] page, input logic [5:0] best);
        logic [4:0] p;
        logic [5:0] s;
        logic [7:0] a;
        logic       sv;
        logic       q [$];
        p = page;
        s = best;
        for (int k = 0; k < TB_LEN + DEC_LEN; k++) begin
            a = {p, s[5:3]};
            expAddr.push_back(a);
            sv = ram[a][s[2:0]];
            if (k >= TB_LEN) q.push_back(s[5]);
            s = {s[4:0], sv};
            p = p - 5'd1;
        end
        if (LIFO) for (int k = q.size() - 1; k >= 0; k--) expBits.push_back(q[k]);
        else      for (int k = 0; k < q.size(); k++) expBits.push_back(q[k]);
    endtask

    // Runs one traceback; cycle 0 is the first cycle after Start is accepted.
    task automatic runOnce(input logic [4:0] page, input logic [5:0] best,
                           input int holdAt, input int holdLen, input int restartAt,
                           output int cycles, output bit busyOk, output bit frozenOk,
                           output bit snapDv, output int dvFirst, output int dvCount,
                           output bit timedOut);
        int         n;
        logic [7:0] snapAddr;
        applyStimulus(page, best);
        obsAddr.delete();
        obsBits.delete();
        @(posedge clk); #1;
        busIf.i_startPage = page;
        busIf.i_bestState = best;
        busIf.i_start     = 1'b1;
        n = 0; busyOk = 1'b1; frozenOk = 1'b1; snapDv = 1'b0; snapAddr = '0;
        dvFirst = -1; dvCount = 0; timedOut = 1'b0;
        forever begin
            @(posedge clk); #1;
            busIf.i_start = (n == restartAt);
            busIf.i_hold  = (n >= holdAt) && (n < holdAt + holdLen);
            @(negedge clk);
            if (n == holdAt) begin
                snapAddr = busIf.o_addressTb;
                snapDv   = busIf.o_decodeValid;
            end else if (holdLen > 0 && n > holdAt && n <= holdAt + holdLen) begin
                if (busIf.o_addressTb !== snapAddr || busIf.o_decodeValid !== snapDv) frozenOk = 1'b0;
            end
            if (busIf.o_done) break;
            if (!busIf.o_busy) busyOk = 1'b0;
            if (busIf.o_decodeValid && !busIf.i_hold) begin
                if (dvFirst < 0) dvFirst = n;
                dvCount++;
            end
            n++;
            if (n > BUDGET) begin
                timedOut = 1'b1;
                break;
            end
        end
        if (busIf.o_busy) busyOk = 1'b0;
        cycles = n;
        busIf.i_hold  = 1'b0;
        busIf.i_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (busIf.o_busy !== 1'b0)        begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busIf.o_busy); end
        if (busIf.o_tbRead !== 1'b0)      begin errors++; $display("[TB] FAIL reset_tbread: got %b, required 0", busIf.o_tbRead); end
        if (busIf.o_addressTb !== 8'h00)  begin errors++; $display("[TB] FAIL reset_addr: got %h, required 00", busIf.o_addressTb); end
        if (busIf.o_decodeValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dv: got %b, required 0", busIf.o_decodeValid); end
        if (busIf.o_decodedBit !== 1'b0)  begin errors++; $display("[TB] FAIL reset_bit: got %b, required 0", busIf.o_decodedBit); end
        if (busIf.o_done !== 1'b0)        begin errors++; $display("[TB] FAIL reset_done: got %b, required 0", busIf.o_done); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_all_zero();
        int cyc, dvF, dvC;
        bit bOk, fOk, sDv, tOut;
        fillRam(1'b0, 8'h00);
        runOnce(5'd10, 6'd0, -1, 0, -1, cyc, bOk, fOk, sDv, dvF, dvC, tOut);
        checks += 3;
        if (tOut)              begin errors++; $display("[TB] FAIL zero_timeout: got timeout, required done"); end
        if (cyc !== EXP_CYCLES) begin errors++; $display("[TB] FAIL zero_length: got %0d, required %0d", cyc, EXP_CYCLES); end
        if (!bOk)              begin errors++; $display("[TB] FAIL zero_busy: got busy glitch, required steady"); end
        checks++;
        if (obsAddr.size() != 8) begin
            errors++; $display("[TB] FAIL zero_reads: got %0d, required 8", obsAddr.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obsAddr[k] !== {5'(10 - k), 3'd0}) begin
                    errors++; $display("[TB] FAIL zero_page%0d: got %h, required %h", k, obsAddr[k], {5'(10 - k), 3'd0});
                end
            end
        end
        checks++;
        if (obsBits.size() != 4 || obsBits.sum() with (int'(item)) != 0) begin
            errors++; $display("[TB] FAIL zero_bits: got %0d bits sum %0d, required 4 bits sum 0", obsBits.size(), obsBits.sum() with (int'(item)));
        end
    endtask

    task automatic test_all_ones();
        int   cyc, dvF, dvC;
        bit   bOk, fOk, sDv, tOut;
        logic want [4];
        fillRam(1'b0, 8'hFF);
        runOnce(5'd20, 6'd0, -1, 0, -1, cyc, bOk, fOk, sDv, dvF, dvC, tOut);
        if (LIFO) want = '{1'b1, 1'b1, 1'b0, 1'b0};
        else      want = '{1'b0, 1'b0, 1'b1, 1'b1};
        checks += 2;
        if (obsAddr.size() != 8 || obsAddr[6][2:0] !== 3'd7 || obsAddr[7][2:0] !== 3'd7) begin
            errors++; $display("[TB] FAIL ones_segment: got %0d reads, required segment 7 at steps 6 and 7", obsAddr.size());
        end
        if (obsBits.size() != 4) begin
            errors++; $display("[TB] FAIL ones_bitcount: got %0d, required 4", obsBits.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obsBits[k] !== want[k]) begin
                    errors++; $display("[TB] FAIL ones_bit%0d: got %b, required %b", k, obsBits[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_page_wrap();
        int         cyc, dvF, dvC;
        bit         bOk, fOk, sDv, tOut;
        logic [4:0] pages [4];
        pages = '{5'd1, 5'd0, 5'd31, 5'd30};
        fillRam(1'b1, 8'h00);
        runOnce(5'd1, 6'd37, -1, 0, -1, cyc, bOk, fOk, sDv, dvF, dvC, tOut);
        checks += 2;
        if (!bOk || tOut)       begin errors++; $display("[TB] FAIL wrap_busy: got glitch/timeout, required steady busy"); end
        if (cyc !== EXP_CYCLES) begin errors++; $display("[TB] FAIL wrap_length: got %0d, required %0d", cyc, EXP_CYCLES); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obsAddr.size() < 4 || obsAddr[k][7:3] !== pages[k]) begin
                errors++; $display("[TB] FAIL wrap_page%0d: got %0d reads, required page %0d", k, obsAddr.size(), pages[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int cyc, dvF, dvC;
        bit bOk, fOk, sDv, tOut;
        fillRam(1'b1, 8'h00);
        runOnce(5'd17, 6'd9, -1, 0, 3, cyc, bOk, fOk, sDv, dvF, dvC, tOut);
        checks += 2;
        if (cyc !== EXP_CYCLES) begin errors++; $display("[TB] FAIL restart_length: got %0d, required %0d", cyc, EXP_CYCLES); end
        if (!bOk || tOut)       begin errors++; $display("[TB] FAIL restart_busy: got glitch/timeout, required steady busy"); end
    endtask

    task automatic test_start_on_done();
        int cyc, dvF, dvC;
        bit bOk, fOk, sDv, tOut;
        runOnce(5'd3, 6'd50, -1, 0, -1, cyc, bOk, fOk, sDv, dvF, dvC, tOut);
        busIf.i_start = 1'b1;
        @(posedge clk); #1 busIf.i_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (busIf.o_busy !== 1'b0 || busIf.o_tbRead !== 1'b0) begin
                errors++; $display("[TB] FAIL start_on_done: got busy=%b tbread=%b, required 0 0", busIf.o_busy, busIf.o_tbRead);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int cyc, dvF, dvC;
        bit bOk, fOk, sDv, tOut;
        applyStimulus(5'd12, 6'd21);
        @(posedge clk); #1;
        busIf.i_startPage = 5'd12;
        busIf.i_bestState = 6'd21;
        busIf.i_start     = 1'b1;
        @(posedge clk); #1 busIf.i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busIf.o_busy !== 1'b0 || busIf.o_tbRead !== 1'b0 || busIf.o_addressTb !== 8'h00) begin
            errors++; $display("[TB] FAIL midrun_reset: got busy=%b tbread=%b addr=%h, required 0 0 00", busIf.o_busy, busIf.o_tbRead, busIf.o_addressTb);
        end
        expAddr.delete();
        expBits.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        runOnce(5'd12, 6'd21, -1, 0, -1, cyc, bOk, fOk, sDv, dvF, dvC, tOut);
        checks++;
        if (cyc !== EXP_CYCLES || tOut) begin
            errors++; $display("[TB] FAIL midrun_restart: got %0d cycles, required %0d", cyc, EXP_CYCLES);
        end
    endtask

    task automatic test_hold();
        int   cycRef, cyc, dvF, dvC, holdAt;
        bit   bOk, fOk, sDv, tOut;
        logic refBits [$];
        holdAt = LIFO ? 2 * (TB_LEN + DEC_LEN) + 1 : 2 * TB_LEN + 3;
        fillRam(1'b1, 8'h00);
        runOnce(5'd7, 6'd13, -1, 0, -1, cycRef, bOk, fOk, sDv, dvF, dvC, tOut);
        refBits = obsBits;
        runOnce(5'd7, 6'd13, holdAt, 3, -1, cyc, bOk, fOk, sDv, dvF, dvC, tOut);
        checks += 4;
        if (cyc !== cycRef + 3) begin errors++; $display("[TB] FAIL hold_length: got %0d, required %0d", cyc, cycRef + 3); end
        if (!fOk)               begin errors++; $display("[TB] FAIL hold_frozen: got outputs changing, required frozen"); end
        if (sDv !== 1'b1)       begin errors++; $display("[TB] FAIL hold_dv: got %b, required 1", sDv); end
        if (obsBits != refBits) begin errors++; $display("[TB] FAIL hold_bits: got %0d bits differing, required same sequence", obsBits.size()); end
    endtask

    task automatic test_lifo_order();
        int   cyc, dvF, dvC;
        bit   bOk, fOk, sDv, tOut;
        logic want [4];
        fillRam(1'b0, 8'hFF);
        runOnce(5'd5, 6'd2, -1, 0, -1, cyc, bOk, fOk, sDv, dvF, dvC, tOut);
        if (LIFO) want = '{1'b1, 1'b1, 1'b0, 1'b1};
        else      want = '{1'b1, 1'b0, 1'b1, 1'b1};
        checks += 2;
        if (dvC !== 4) begin errors++; $display("[TB] FAIL order_count: got %0d, required 4", dvC); end
        if (dvF !== (LIFO ? 2 * (TB_LEN + DEC_LEN) : 2 * TB_LEN + 1)) begin
            errors++; $display("[TB] FAIL order_first: got %0d, required %0d", dvF, LIFO ? 2 * (TB_LEN + DEC_LEN) : 2 * TB_LEN + 1);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obsBits.size() != 4 || obsBits[k] !== want[k]) begin
                errors++; $display("[TB] FAIL order_bit%0d: got %0d bits, required bit %b", k, obsBits.size(), want[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, dvF, dvC;
        bit bOk, fOk, sDv, tOut;
        fillRam(1'b1, 8'h00);
        for (int r = 0; r < 2; r++) begin
            runOnce(5'(9 + 13 * r), 6'(11 + 29 * r), -1, 0, -1, cyc, bOk, fOk, sDv, dvF, dvC, tOut);
            checks++;
            if (cyc !== EXP_CYCLES || !bOk || tOut) begin
                errors++; $display("[TB] FAIL b2b_run%0d: got %0d cycles, required %0d", r, cyc, EXP_CYCLES);
            end
        end
    endtask

    task automatic checkOutput();
        checks++;
        if (expAddr.size() != 0 || expBits.size() != 0) begin
            errors++; $display("[TB] FAIL drained: got %0d addr %0d bits pending, required 0 0", expAddr.size(), expBits.size());
        end
    endtask

    initial begin
        busIf.i_hold      = 1'b0;
        busIf.i_start     = 1'b0;
        busIf.i_startPage = '0;
        busIf.i_bestState = '0;
        test_reset();
        test_all_zero();
        test_all_ones();
        test_page_wrap();
        test_start_ignored();
        test_start_on_done();
        test_reset_midrun();
        test_hold();
        test_lifo_order();
        test_back_to_back();
        checkOutput();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
